fc_layer_param: RTL and testbench
=================================

FC_LAYER_PARAM -- requirements
Module: fc_layer_param

Interface
REQ-001 SHALL have parameter N_OUT, default 2, number of output neurons computed in parallel.
REQ-002 SHALL have parameter K, default 9, int8 elements per input beat.
REQ-003 SHALL have parameter N_BEATS, default 32, beats per inference.
REQ-004 SHALL have parameter ACC_W, default 32, signed accumulator width.
REQ-005 SHALL have parameter M0, default 11, unsigned 4-bit requant multiplier.
REQ-006 SHALL have parameter SHIFT, default 15, requant right shift.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 valid_i  input  1  input beat valid.
REQ-010 ready_o  output  1  block can accept a beat.
REQ-011 data_i  input  K*8  signed int8 activations; element j at bits [8j+7:8j].
REQ-012 weight_i  input  N_OUT*K*8  signed int8 weights; neuron n, element j at bits [8(nK+j)+7 : 8(nK+j)].
REQ-013 bias_i  input  N_OUT*16  signed int16 bias per neuron; consumed on beat 0 only.
REQ-014 relu_en  input  1  mode: clamp negative results to 0; sampled in REQ.
REQ-015 valid_o  output  1  result valid.
REQ-016 ready_i  input  1  downstream accepts the result.
REQ-017 data_o  output  N_OUT*8  signed int8 results; neuron n at bits [8n+7:8n].

Function
REQ-018 The FSM SHALL have the states IDLE, MAC and REQ; ready_o = (state==IDLE).
REQ-019 In IDLE, valid_i&&ready_o SHALL register data_i, weight_i and bias_i, clear the element counter and enter MAC; valid_i while ready_o=0 SHALL be ignored.
REQ-020 MAC SHALL last exactly K cycles; on element j, acc[n] <= acc[n] + data[j]*w[n][j], with the 16-bit signed product sign-extended.
REQ-021 On element 0 of beat 0, acc[n] SHALL be loaded with sext(bias[n]) + product, discarding the prior contents.
REQ-022 Accumulation SHALL wrap modulo 2^ACC_W.
REQ-023 Leaving MAC SHALL go to REQ when the beat counter equals N_BEATS-1; otherwise it SHALL increment the beat counter and return to IDLE.
REQ-024 In REQ, each neuron SHALL compute r = floor(acc*M0 / 2^SHIFT) using full-width signed arithmetic, with no intermediate truncation.
REQ-025 The requant result SHALL saturate to [-128, 127]; with relu_en=1, r<0 SHALL give 0.
REQ-026 In REQ with (!valid_o || ready_i), data_o SHALL load, valid_o SHALL be set, the beat counter SHALL clear, and the FSM SHALL return to IDLE.
REQ-027 Otherwise the FSM SHALL stall in REQ, holding acc, data_o and ready_o=0.
REQ-028 valid_o SHALL clear on valid_o&&ready_i, unless a new result loads in the same cycle, in which case it stays 1.
REQ-029 data_o SHALL be stable while valid_o=1 and ready_i=0.
REQ-030 Latency: valid_o SHALL rise K+1 cycles after the accepting edge of the last beat, given no stall.
REQ-031 Peak throughput SHALL be one beat per K+1 cycles.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, clear all counters, acc and registered inputs, and set valid_o=0, data_o=0 and ready_o=1 after release.
REQ-033 Reset mid-inference SHALL discard partial sums; the next accepted beat SHALL be beat 0.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the int8 saturation limits (8'h7F, 8'h80).
REQ-035 The design SHALL contain one sub-module, fc_mac_lane, instantiated N_OUT times; each lane SHALL hold one accumulator with bias-load and enable inputs.

Verification (defaults unless stated)
REQ-036 All data=1, w0=1, w1=-1, bias=0, 32 beats -> acc 288/-288; data_o n0=0, n1=-1 (floor).
REQ-037 As REQ-036 with relu_en=1 -> n0=0, n1=0.
REQ-038 data=127, w0=127, w1=-128 -> n0=127 and n1=-128, both saturated.
REQ-039 data=0, bias0=3000, bias1=-3000 -> n0=1, n1=-2; bias SHALL be counted once, not per beat.
REQ-040 Backpressure: ready_i=0 with a second inference complete -> FSM stalls in REQ, ready_o=0, first data_o held; ready_i=1 -> second result loads on the next edge.
REQ-041 rst_n pulse at beat 10 of an inference, then a fresh 32 beats per REQ-036 -> identical REQ-036 result, with no residual accumulation.

Source files
------------

// File: rtl/fc_layer_param_pkg.sv
// Shared types and constants for the fully-connected layer block.
package fc_layer_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_REQ  = 2'd2
  } fc_state_e;

  localparam logic [7:0] INT8_MAX = 8'h7F;
  localparam logic [7:0] INT8_MIN = 8'h80;

endpackage

// File: rtl/fc_layer_param_if.sv
// Beat input / result output handshake bundle for fc_layer_param.
interface fc_layer_param_if #(
  parameter int N_OUT = 2,
  parameter int K     = 9
);
  logic                   valid_i;
  logic                   ready_o;
  logic [K*8-1:0]         data_i;
  logic [N_OUT*K*8-1:0]   weight_i;
  logic [N_OUT*16-1:0]    bias_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [N_OUT*8-1:0]     data_o;

  modport master (
    output valid_i, data_i, weight_i, bias_i, ready_i,
    input  ready_o, valid_o, data_o
  );

  modport slave (
    input  valid_i, data_i, weight_i, bias_i, ready_i,
    output ready_o, valid_o, data_o
  );
endinterface

// File: rtl/fc_layer_param_mac_lane.sv
// One neuron accumulator: bias-load on the first element of an inference, else accumulate.
module fc_mac_lane #(
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    load_bias_i,
  input  logic signed [15:0]      bias_i,
  input  logic signed [7:0]       act_i,
  input  logic signed [7:0]       wgt_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] bias_x;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Sized casts of signed operands sign-extend; the add wraps modulo 2^ACC_W.
  always_comb begin
    prod   = act_i * wgt_i;
    prod_x = ACC_W'(prod);
    bias_x = ACC_W'(bias_i);
    acc_d  = acc_q;
    if (en_i) begin
      acc_d = load_bias_i ? (bias_x + prod_x) : (acc_q + prod_x);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer_param.sv
// Int8 fully-connected layer: N_OUT parallel MAC lanes over N_BEATS beats of K elements,
// followed by requantisation (acc*M0 >> SHIFT, floor) and int8 saturation / optional ReLU.
module fc_layer_param
  import fc_layer_param_pkg::*;
#(
  parameter int          N_OUT   = 2,
  parameter int          K       = 9,
  parameter int          N_BEATS = 32,
  parameter int          ACC_W   = 32,
  parameter int unsigned M0      = 11,
  parameter int          SHIFT   = 15
) (
  input logic             clk,
  input logic             rst_n,
  input logic             relu_en,
  fc_layer_param_if.slave bus
);

  localparam int EW = (K > 1) ? $clog2(K) : 1;
  localparam int BW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int PW = ACC_W + 5;
  localparam logic signed [4:0]    M0_S   = {1'b0, M0[3:0]};
  localparam logic signed [PW-1:0] SAT_HI = PW'(signed'(INT8_MAX));
  localparam logic signed [PW-1:0] SAT_LO = PW'(signed'(INT8_MIN));

  fc_state_e state_q, state_d;
  logic [K*8-1:0]       data_q, data_d;
  logic [N_OUT*K*8-1:0] weight_q, weight_d;
  logic [N_OUT*16-1:0]  bias_q, bias_d;
  logic [EW-1:0]        elem_q, elem_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 valid_q, valid_d;
  logic [N_OUT*8-1:0]   dout_q, dout_d;

  logic elem_last, beat_last, out_load, lane_en, lane_load;
  logic signed [ACC_W-1:0] acc    [N_OUT];
  logic signed [PW-1:0]    scaled [N_OUT];
  logic [7:0]              rq     [N_OUT];

  assign elem_last = (elem_q == EW'(K - 1));
  assign beat_last = (beat_q == BW'(N_BEATS - 1));
  assign out_load  = (state_q == ST_REQ) && (!valid_q || bus.ready_i);
  assign lane_en   = (state_q == ST_MAC);
  assign lane_load = (beat_q == '0) && (elem_q == '0);

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    fc_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (lane_en),
      .load_bias_i (lane_load),
      .bias_i      (bias_q[16*g +: 16]),
      .act_i       (data_q[8*int'(elem_q) +: 8]),
      .wgt_i       (weight_q[8*(g*K + int'(elem_q)) +: 8]),
      .acc_o       (acc[g])
    );
  end

  // Full-width product then arithmetic shift gives floor division without truncation.
  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      scaled[n] = (PW'(acc[n]) * PW'(M0_S)) >>> SHIFT;
      if (relu_en && scaled[n][PW-1]) rq[n] = 8'h00;
      else if (scaled[n] > SAT_HI)    rq[n] = INT8_MAX;
      else if (scaled[n] < SAT_LO)    rq[n] = INT8_MIN;
      else                            rq[n] = scaled[n][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.valid_i) state_d = ST_MAC;
      ST_MAC:  if (elem_last)   state_d = beat_last ? ST_REQ : ST_IDLE;
      ST_REQ:  if (out_load)    state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    weight_d = weight_q;
    bias_d   = bias_q;
    elem_d   = elem_q;
    beat_d   = beat_q;
    dout_d   = dout_q;
    valid_d  = valid_q && !bus.ready_i;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          data_d   = bus.data_i;
          weight_d = bus.weight_i;
          bias_d   = bus.bias_i;
          elem_d   = '0;
        end
      end
      ST_MAC: begin
        elem_d = elem_last ? '0 : elem_q + 1'b1;
        if (elem_last && !beat_last) beat_d = beat_q + 1'b1;
      end
      ST_REQ: begin
        if (out_load) begin
          for (int n = 0; n < N_OUT; n++) dout_d[8*n +: 8] = rq[n];
          valid_d = 1'b1;
          beat_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      elem_q   <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      data_q   <= data_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
      elem_q   <= elem_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.valid_o = valid_q;
  assign bus.data_o  = dout_q;

endmodule

// File: tb/tb_fc_layer_param.sv
// Directed bench for fc_layer_param: vector table of whole inferences plus backpressure and reset sequences.
module tb_fc_layer_param;

  localparam int N_OUT = 2;
  localparam int K     = 9;
  localparam int NB    = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic relu_en;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_layer_param_if #(.N_OUT(N_OUT), .K(K)) bus ();

  fc_layer_param #(.N_OUT(N_OUT), .K(K), .N_BEATS(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .relu_en (relu_en),
    .bus     (bus)
  );

  typedef struct {
    string             name;
    logic [K*8-1:0]    d;
    logic [K*8-1:0]    w0;
    logic [K*8-1:0]    w1;
    logic [15:0]       b0;
    logic [15:0]       b1;
    logic              relu;
    int                e0;
    int                e1;
  } vec_t;

  vec_t vt [7];

  function automatic logic [K*8-1:0] rep(input logic [7:0] x);
    logic [K*8-1:0] r;
    for (int j = 0; j < K; j++) r[8*j +: 8] = x;
    return r;
  endfunction

  function automatic vec_t mk(input string n, input logic [K*8-1:0] d, w0, w1,
                              input int b0, b1, input logic relu, input int e0, e1);
    vec_t v;
    v.name = n; v.d = d; v.w0 = w0; v.w1 = w1;
    v.b0 = 16'(b0); v.b1 = 16'(b1); v.relu = relu; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_beat(input vec_t v, output int acc_cyc);
    int g;
    @(negedge clk);
    g = 0;
    while (!bus.ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus.ready_o) begin
      total++; bad++;
      $display("FAIL %s ready_o timeout: got 0 expected 1", v.name);
    end
    bus.data_i   = v.d;
    bus.weight_i = {v.w1, v.w0};
    bus.bias_i   = {v.b1, v.b0};
    bus.valid_i  = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    bus.valid_i = 1'b0;
  endtask

  task automatic send_beats(input vec_t v, input int n, output int first_gap);
    int c0, c;
    c0 = 0;
    first_gap = 0;
    relu_en = v.relu;
    for (int b = 0; b < n; b++) begin
      send_beat(v, c);
      if (b == 0) c0 = c;
      if (b == 1) first_gap = c - c0;
    end
  endtask

  task automatic wait_valid(output int lat);
    int start;
    start = cyc;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.valid_o) break;
      @(posedge clk);
      #1;
    end
    lat = cyc - start;
  endtask

  task automatic check_out(input string nm, input int e0, input int e1);
    check({nm, " n0"}, int'(signed'(bus.data_o[7:0])),  e0);
    check({nm, " n1"}, int'(signed'(bus.data_o[15:8])), e1);
  endtask

  initial begin
    int gap, lat;
    logic [K*8-1:0] pd, pw1;

    for (int j = 0; j < K; j++) begin
      pd[8*j +: 8]  = 8'(j + 1);
      pw1[8*j +: 8] = 8'(j - 4);
    end
    vt[0] = mk("ones",      rep(8'd1),   rep(8'd1),   rep(8'hFF), 0,    0,     1'b0, 0,   -1);
    vt[1] = mk("ones_relu", rep(8'd1),   rep(8'd1),   rep(8'hFF), 0,    0,     1'b1, 0,   0);
    vt[2] = mk("sat",       rep(8'd127), rep(8'd127), rep(8'h80), 0,    0,     1'b0, 127, -128);
    vt[3] = mk("bias_once", rep(8'd0),   rep(8'd1),   rep(8'd1),  3000, -3000, 1'b0, 1,   -2);
    vt[4] = mk("neg_relu",  rep(8'h80),  rep(8'h80),  rep(8'd1),  0,    0,     1'b1, 127, 0);
    vt[5] = mk("mixed",     rep(8'd10),  rep(8'd3),   rep(8'hFD), 100,  -100,  1'b0, 2,   -3);
    vt[6] = mk("per_elem",  pd,          rep(8'd1),   pw1,        1539, 1059,  1'b0, 1,   1);

    rst_n       = 1'b0;
    relu_en     = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.data_i  = '0;
    bus.weight_i = '0;
    bus.bias_i  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst ready_o", int'(bus.ready_o), 1);
    check("rst valid_o", int'(bus.valid_o), 0);
    check("rst data_o",  int'(bus.data_o),  0);

    for (int i = 0; i < 7; i++) begin
      send_beats(vt[i], NB, gap);
      check({vt[i].name, " beat gap"}, gap, K + 1);
      wait_valid(lat);
      check({vt[i].name, " latency"}, lat, K + 1);
      check_out(vt[i].name, vt[i].e0, vt[i].e1);
      @(posedge clk);
      #1;
      check({vt[i].name, " valid clear"}, int'(bus.valid_o), 0);
    end

    // Backpressure: first result held while a second inference completes and stalls.
    bus.ready_i = 1'b0;
    send_beats(vt[0], NB, gap);
    wait_valid(lat);
    check("bp first latency", lat, K + 1);
    check_out("bp first", 0, -1);
    send_beats(vt[2], NB, gap);
    repeat (K + 4) @(posedge clk);
    #1;
    check("bp stall ready_o", int'(bus.ready_o), 0);
    check("bp stall valid_o", int'(bus.valid_o), 1);
    check_out("bp held", 0, -1);
    @(negedge clk);
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("bp reload valid_o", int'(bus.valid_o), 1);
    check_out("bp second", 127, -128);
    check("bp ready_o back", int'(bus.ready_o), 1);
    @(posedge clk);
    #1;
    check("bp valid clear", int'(bus.valid_o), 0);

    // Reset mid-inference discards partial state; the next inference starts at beat 0.
    send_beats(vt[2], 10, gap);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid rst ready_o", int'(bus.ready_o), 1);
    check("mid rst valid_o", int'(bus.valid_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid rst data_o", int'(bus.data_o), 0);
    send_beats(vt[0], NB, gap);
    wait_valid(lat);
    check("post rst latency", lat, K + 1);
    check_out("post rst", 0, -1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
